// File: rtl/edge_cfg_pkg.sv
// edge_cfg_pkg
//   Shared types and constants for the edge pipeline configuration master.
//   - cfg_state_t : sequencer state encoding (also exported on state_dbg)
//   - REG_*       : register addresses on the Top_Level slave port
//   - ERR_*       : err_code values
//   - BUSY_CODE_DEFAULT : status word meaning "accelerator busy"
//   - gap_after() : maps a write-beat state to the gap state that follows it
package edge_cfg_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_WR_DIM,
        ST_GAP0,
        ST_WR_RADDR,
        ST_GAP1,
        ST_WR_WADDR,
        ST_GAP2,
        ST_WAIT_BUSY,
        ST_WAIT_IDLE,
        ST_ERR
    } cfg_state_t;

    localparam int unsigned REG_DIM   = 0;
    localparam int unsigned REG_RADDR = 1;
    localparam int unsigned REG_WADDR = 2;

    localparam logic [1:0] ERR_NONE  = 2'd0;
    localparam logic [1:0] ERR_DIMS  = 2'd1;
    localparam logic [1:0] ERR_READY = 2'd2;
    localparam logic [1:0] ERR_BUSY  = 2'd3;

    localparam logic [31:0] BUSY_CODE_DEFAULT = 32'hFFFF_FFFF;

    // Each write beat is followed by exactly one idle gap cycle.
    function automatic cfg_state_t gap_after(input cfg_state_t s);
        case (s)
            ST_WR_DIM:   return ST_GAP0;
            ST_WR_RADDR: return ST_GAP1;
            default:     return ST_GAP2;
        endcase
    endfunction

endpackage

// File: rtl/edge_cfg_master_if.sv
// edge_cfg_master_if
//   Register-write / status-poll port between edge_cfg_master and the
//   Top_Level slave configuration port.
//   Signals:
//     s_haddr  : register address            (master -> slave)
//     s_hwdata : register write data         (master -> slave)
//     s_hwrite : write strobe                (master -> slave)
//     s_hready : responder ready             (slave -> master)
//     s_hrdata : status / read data          (slave -> master)
//   Handshake: a write beat is transferred on a rising clock edge where
//   s_hwrite=1 and s_hready=1. While s_hwrite=1 and s_hready=0 the master
//   holds s_haddr, s_hwdata and s_hwrite stable. With s_hwrite=0 the slave
//   presents the register selected by s_haddr on s_hrdata; s_hready=1 marks
//   that s_hrdata is valid.
interface edge_cfg_master_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] s_haddr;
    logic [DATA_W-1:0] s_hwdata;
    logic              s_hwrite;
    logic              s_hready;
    logic [DATA_W-1:0] s_hrdata;

    modport master (
        output s_haddr,
        output s_hwdata,
        output s_hwrite,
        input  s_hready,
        input  s_hrdata
    );

    modport slave (
        input  s_haddr,
        input  s_hwdata,
        input  s_hwrite,
        output s_hready,
        output s_hrdata
    );
endinterface

// File: rtl/edge_cfg_master_dim_crop.sv
// dim_crop
//   Pure combinational crop of raw image dimensions to the alignment the edge
//   pipeline needs: width trimmed to 8 + 12k, height trimmed to 2 + 3k.
//   Ports:
//     width, height : raw image dimensions in pixels
//     cw, ch        : cropped dimensions (meaningful only when dims_ok=1)
//     dims_ok       : width >= 8 and height >= 5
module dim_crop (
    input  logic [15:0] width,
    input  logic [15:0] height,
    output logic [15:0] cw,
    output logic [15:0] ch,
    output logic        dims_ok
);
    logic [15:0] xoff;
    logic [15:0] yoff;
    logic [15:0] xpad;
    logic [15:0] ypad;

    always_comb begin
        dims_ok = (width >= 16'd8) && (height >= 16'd5);
        // For undersized inputs the subtraction wraps; the result is unused
        // because dims_ok is low.
        xoff    = width - 16'd8;
        yoff    = height - 16'd2;
        xpad    = xoff % 16'd12;
        ypad    = yoff % 16'd3;
        cw      = width - xpad;
        ch      = height - ypad;
    end
endmodule

// File: rtl/edge_cfg_master.sv
// edge_cfg_master
//   Configures the edge accelerator: crops the image dimensions, writes the
//   dimension, read-base and write-base registers, then polls status until
//   the accelerator has gone busy and back to idle.
//   Ports:
//     clk, rst                : clock, asynchronous active-high reset
//     start                   : one-cycle request, honoured in IDLE/ERR only
//     img_width, img_height   : raw image dimensions
//     rd_base, wr_base        : source / destination pixel base addresses
//     cfg                     : master side of the register port
//     crop_width, crop_height : cropped dimensions latched at accept
//     busy                    : sequence in progress
//     done                    : one-cycle pulse on successful completion
//     error, err_code         : sticky failure flag and cause
//     state_dbg               : current sequencer state
module edge_cfg_master
    import edge_cfg_pkg::*;
#(
    parameter int              ADDR_W        = 32,
    parameter int              DATA_W        = 32,
    parameter logic [31:0]     BUSY_CODE     = BUSY_CODE_DEFAULT,
    parameter int              STATUS_ADDR   = 2,
    parameter int              READY_TIMEOUT = 64,
    parameter int              BUSY_TIMEOUT  = 256
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [15:0]         img_width,
    input  logic [15:0]         img_height,
    input  logic [31:0]         rd_base,
    input  logic [31:0]         wr_base,
    edge_cfg_master_if.master   cfg,
    output logic [15:0]         crop_width,
    output logic [15:0]         crop_height,
    output logic                busy,
    output logic                done,
    output logic                error,
    output logic [1:0]          err_code,
    output cfg_state_t          state_dbg
);
    localparam int RDY_W = $clog2(READY_TIMEOUT) + 1;
    localparam int BSY_W = $clog2(BUSY_TIMEOUT) + 1;
    // Timeout fires on the edge where the counter would reach the limit.
    localparam logic [RDY_W-1:0] RDY_LAST = RDY_W'(READY_TIMEOUT - 1);
    localparam logic [BSY_W-1:0] BSY_LAST = BSY_W'(BUSY_TIMEOUT - 1);
    localparam logic [DATA_W-1:0] BUSY_WORD = DATA_W'(BUSY_CODE);

    cfg_state_t        state;
    logic [RDY_W-1:0]  rdy_cnt;
    logic [BSY_W-1:0]  busy_cnt;
    logic [31:0]       rd_q;
    logic [31:0]       wr_q;
    logic [ADDR_W-1:0] haddr_q;
    logic [DATA_W-1:0] hwdata_q;
    logic              hwrite_q;

    logic [15:0]       cw;
    logic [15:0]       ch;
    logic              dims_ok;

    dim_crop u_dim_crop (
        .width   (img_width),
        .height  (img_height),
        .cw      (cw),
        .ch      (ch),
        .dims_ok (dims_ok)
    );

    assign cfg.s_haddr  = haddr_q;
    assign cfg.s_hwdata = hwdata_q;
    assign cfg.s_hwrite = hwrite_q;
    assign state_dbg    = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            rdy_cnt     <= '0;
            busy_cnt    <= '0;
            rd_q        <= '0;
            wr_q        <= '0;
            haddr_q     <= '0;
            hwdata_q    <= '0;
            hwrite_q    <= 1'b0;
            crop_width  <= '0;
            crop_height <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
            err_code    <= ERR_NONE;
        end else begin
            done <= 1'b0;
            case (state)
                // ERR re-arms exactly like IDLE; error stays sticky until a
                // start is accepted.
                ST_IDLE, ST_ERR: begin
                    if (start) begin
                        if (dims_ok) begin
                            state       <= ST_WR_DIM;
                            busy        <= 1'b1;
                            error       <= 1'b0;
                            err_code    <= ERR_NONE;
                            crop_width  <= cw;
                            crop_height <= ch;
                            rd_q        <= rd_base;
                            wr_q        <= wr_base;
                            haddr_q     <= ADDR_W'(REG_DIM);
                            hwdata_q    <= DATA_W'({cw, ch});
                            hwrite_q    <= 1'b1;
                            rdy_cnt     <= '0;
                            busy_cnt    <= '0;
                        end else begin
                            state    <= ST_ERR;
                            busy     <= 1'b0;
                            error    <= 1'b1;
                            err_code <= ERR_DIMS;
                        end
                    end
                end

                ST_WR_DIM, ST_WR_RADDR, ST_WR_WADDR: begin
                    if (cfg.s_hready) begin
                        state    <= gap_after(state);
                        hwrite_q <= 1'b0;
                        rdy_cnt  <= '0;
                    end else if (rdy_cnt == RDY_LAST) begin
                        state    <= ST_ERR;
                        hwrite_q <= 1'b0;
                        busy     <= 1'b0;
                        error    <= 1'b1;
                        err_code <= ERR_READY;
                    end else begin
                        rdy_cnt <= rdy_cnt + 1'b1;
                    end
                end

                ST_GAP0: begin
                    state    <= ST_WR_RADDR;
                    haddr_q  <= ADDR_W'(REG_RADDR);
                    hwdata_q <= DATA_W'(rd_q);
                    hwrite_q <= 1'b1;
                end

                ST_GAP1: begin
                    state    <= ST_WR_WADDR;
                    haddr_q  <= ADDR_W'(REG_WADDR);
                    hwdata_q <= DATA_W'(wr_q);
                    hwrite_q <= 1'b1;
                end

                ST_GAP2: begin
                    state    <= ST_WAIT_BUSY;
                    haddr_q  <= ADDR_W'(STATUS_ADDR);
                    busy_cnt <= '0;
                end

                ST_WAIT_BUSY: begin
                    if (cfg.s_hrdata == BUSY_WORD) begin
                        state <= ST_WAIT_IDLE;
                    end else if (busy_cnt == BSY_LAST) begin
                        state    <= ST_ERR;
                        busy     <= 1'b0;
                        error    <= 1'b1;
                        err_code <= ERR_BUSY;
                    end else begin
                        busy_cnt <= busy_cnt + 1'b1;
                    end
                end

                // No timeout here: a frame may take arbitrarily long.
                ST_WAIT_IDLE: begin
                    if (cfg.s_hready && (cfg.s_hrdata != BUSY_WORD)) begin
                        state   <= ST_IDLE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        haddr_q <= '0;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_edge_cfg_master.sv
module tb_edge_cfg_master;
    import edge_cfg_pkg::*;

    localparam int          READY_TIMEOUT = 64;
    localparam int          BUSY_TIMEOUT  = 256;
    localparam logic [31:0] BUSY          = 32'hFFFF_FFFF;

    // ---------------- clock / reset ----------------
    logic tb_clk = 1'b0;
    logic rst;
    always #5 tb_clk = ~tb_clk;

    logic        start;
    logic [15:0] img_width;
    logic [15:0] img_height;
    logic [31:0] rd_base;
    logic [31:0] wr_base;
    logic [15:0] crop_width;
    logic [15:0] crop_height;
    logic        busy;
    logic        done;
    logic        error;
    logic [1:0]  err_code;
    cfg_state_t  state_dbg;

    edge_cfg_master_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    edge_cfg_master #(
        .ADDR_W        (32),
        .DATA_W        (32),
        .BUSY_CODE     (BUSY),
        .STATUS_ADDR   (2),
        .READY_TIMEOUT (READY_TIMEOUT),
        .BUSY_TIMEOUT  (BUSY_TIMEOUT)
    ) dut (
        .clk         (tb_clk),
        .rst         (rst),
        .start       (start),
        .img_width   (img_width),
        .img_height  (img_height),
        .rd_base     (rd_base),
        .wr_base     (wr_base),
        .cfg         (bus),
        .crop_width  (crop_width),
        .crop_height (crop_height),
        .busy        (busy),
        .done        (done),
        .error       (error),
        .err_code    (err_code),
        .state_dbg   (state_dbg)
    );

    // ---------------- monitors ----------------
    int hwrite_cycles = 0;
    int overlap_cycles = 0;
    always @(negedge tb_clk) begin
        if (bus.s_hwrite) hwrite_cycles++;
        if (done && error) overlap_cycles++;
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge tb_clk);
        #1;
    endtask

    task automatic do_start(input logic [15:0] w, input logic [15:0] h,
                            input logic [31:0] rb, input logic [31:0] wb);
        img_width  = w;
        img_height = h;
        rd_base    = rb;
        wr_base    = wb;
        start      = 1'b1;
        tick();
        start      = 1'b0;
    endtask

    task automatic expect_write(input string tag, input logic [31:0] addr, input logic [31:0] data);
        check({tag, " hwrite"}, bus.s_hwrite, 1);
        check({tag, " haddr"}, bus.s_haddr, addr);
        check({tag, " hwdata"}, bus.s_hwdata, data);
    endtask

    // Responder reports busy for busy_cycles cycles, then idle; waits for done.
    task automatic finish_frame(input string tag, input int busy_cycles);
        logic got;
        bus.s_hready = 1'b1;
        bus.s_hrdata = BUSY;
        repeat (busy_cycles) tick();
        bus.s_hrdata = 32'h0;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            tick();
            if (done) got = 1'b1;
        end
        check({tag, " done"}, got, 1);
        check({tag, " err_code"}, err_code, 0);
        check({tag, " busy after done"}, busy, 0);
        tick();
        check({tag, " done pulse width"}, done, 0);
    endtask

    // ---------------- stimulus ----------------
    int mark;

    initial begin
        rst          = 1'b1;
        start        = 1'b0;
        img_width    = '0;
        img_height   = '0;
        rd_base      = '0;
        wr_base      = '0;
        bus.s_hready = 1'b1;
        bus.s_hrdata = 32'h0;

        // reset state
        repeat (2) @(posedge tb_clk);
        #1;
        check("reset state", state_dbg, ST_IDLE);
        check("reset hwrite", bus.s_hwrite, 0);
        check("reset busy", busy, 0);
        check("reset error", error, 0);
        rst = 1'b0;
        tick();

        // ---- test 1: 100x50 nominal frame ----
        do_start(16'd100, 16'd50, 32'd1, 32'd200000);
        expect_write("t1 dim", 32'd0, 32'h005C_0032);
        check("t1 crop_w", crop_width, 92);
        check("t1 crop_h", crop_height, 50);
        check("t1 busy", busy, 1);
        tick();
        check("t1 gap0 hwrite", bus.s_hwrite, 0);
        check("t1 gap0 haddr", bus.s_haddr, 0);
        tick();
        expect_write("t1 raddr", 32'd1, 32'h0000_0001);
        tick();
        check("t1 gap1 hwrite", bus.s_hwrite, 0);
        check("t1 gap1 haddr", bus.s_haddr, 1);
        tick();
        expect_write("t1 waddr", 32'd2, 32'h0003_0D40);
        tick();
        check("t1 gap2 hwrite", bus.s_hwrite, 0);
        check("t1 gap2 haddr", bus.s_haddr, 2);
        tick();
        check("t1 wait_busy state", state_dbg, ST_WAIT_BUSY);
        check("t1 status haddr", bus.s_haddr, 2);
        bus.s_hrdata = BUSY;
        repeat (4) tick();
        // start while busy must be ignored, even with bad dims
        do_start(16'd7, 16'd3, 32'd9, 32'd9);
        check("t1 ignored start error", error, 0);
        check("t1 ignored start busy", busy, 1);
        check("t1 crop kept", crop_width, 92);
        repeat (5) tick();
        check("t1 wait_idle state", state_dbg, ST_WAIT_IDLE);
        check("t1 no early done", done, 0);
        bus.s_hrdata = 32'h0;
        tick();
        check("t1 done", done, 1);
        check("t1 busy cleared", busy, 0);
        check("t1 err_code", err_code, 0);
        check("t1 idle", state_dbg, ST_IDLE);
        tick();
        check("t1 done one cycle", done, 0);

        // ---- test 2: bad dims ----
        mark = hwrite_cycles;
        do_start(16'd7, 16'd50, 32'd1, 32'd2);
        check("t2 error", error, 1);
        check("t2 err_code", err_code, 1);
        check("t2 busy", busy, 0);
        do_start(16'd8, 16'd4, 32'd1, 32'd2);
        check("t2 h=4 err_code", err_code, 1);
        repeat (3) tick();
        check("t2 no hwrite", hwrite_cycles - mark, 0);

        // ---- test 3: minimum dims, s_hready stall in WR_RADDR ----
        do_start(16'd8, 16'd5, 32'd1, 32'h55);
        check("t3 error cleared", error, 0);
        check("t3 err_code cleared", err_code, 0);
        expect_write("t3 dim", 32'd0, 32'h0008_0005);
        tick();
        tick();
        bus.s_hready = 1'b0;
        expect_write("t3 hold0", 32'd1, 32'd1);
        for (int i = 1; i <= 3; i++) begin
            tick();
            expect_write($sformatf("t3 hold%0d", i), 32'd1, 32'd1);
        end
        bus.s_hready = 1'b1;
        tick();
        check("t3 gap1 state", state_dbg, ST_GAP1);
        check("t3 gap1 hwrite", bus.s_hwrite, 0);
        finish_frame("t3", 10);

        // ---- test 4: s_hready stuck low at WR_DIM ----
        bus.s_hready = 1'b0;
        do_start(16'd640, 16'd480, 32'h100, 32'h200);
        expect_write("t4 dim", 32'd0, 32'h0278_01DF);
        repeat (READY_TIMEOUT - 1) tick();
        check("t4 no early timeout", error, 0);
        check("t4 still writing", bus.s_hwrite, 1);
        tick();
        check("t4 timeout error", error, 1);
        check("t4 err_code", err_code, 2);
        check("t4 hwrite dropped", bus.s_hwrite, 0);
        check("t4 busy dropped", busy, 0);
        bus.s_hready = 1'b1;
        do_start(16'd640, 16'd480, 32'h100, 32'h200);
        check("t4 rearm error", error, 0);
        expect_write("t4 rearm dim", 32'd0, 32'h0278_01DF);
        finish_frame("t4b", 10);

        // ---- test 5: status never busy ----
        bus.s_hrdata = 32'h0;
        do_start(16'd31, 16'd18, 32'h10, 32'h20);
        expect_write("t5 dim", 32'd0, 32'h0014_0011);
        repeat (6) tick();
        check("t5 wait_busy", state_dbg, ST_WAIT_BUSY);
        repeat (BUSY_TIMEOUT - 1) tick();
        check("t5 no early timeout", error, 0);
        tick();
        check("t5 timeout error", error, 1);
        check("t5 err_code", err_code, 3);
        check("t5 no done", done, 0);

        // ---- test 6: async reset in WR_WADDR ----
        do_start(16'd1920, 16'd1080, 32'hA000, 32'hB000);
        check("t6 error cleared", error, 0);
        repeat (4) tick();
        expect_write("t6 waddr", 32'd2, 32'h0000_B000);
        rst = 1'b1;
        #1;
        check("t6 rst hwrite", bus.s_hwrite, 0);
        check("t6 rst haddr", bus.s_haddr, 0);
        check("t6 rst hwdata", bus.s_hwdata, 0);
        check("t6 rst busy", busy, 0);
        check("t6 rst crop_w", crop_width, 0);
        check("t6 rst state", state_dbg, ST_IDLE);
        #2;
        rst = 1'b0;
        tick();
        do_start(16'd1920, 16'd1080, 32'hA000, 32'hB000);
        expect_write("t6 replay dim", 32'd0, 32'h077C_0437);
        finish_frame("t6", 10);

        check("done/error overlap", overlap_cycles, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
